dom: RTL and testbench

DOM -- requirements
Module: dom

---
 rtl/dom.sv | 122 ++++++++++++
 tb/tb_dom.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dom.sv
// dom: blinks "DOM" in Morse code on a single LED, repeating forever.
// A small element/gap state machine walks the 38-unit sequence.
// A unit-cycle counter stretches each unit to UNIT_CYCLES clocks.
module dom #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int UNIT_CYCLES = 10_000_000
) (
    input  logic iCLK,
    input  logic iRST,
    output logic oLED
);

    localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(UNIT_CYCLES - 1);

    localparam logic [1:0] MARK     = 2'd0;
    localparam logic [1:0] ELEM_GAP = 2'd1;
    localparam logic [1:0] CHAR_GAP = 2'd2;
    localparam logic [1:0] WORD_GAP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       char_q, char_d;
    logic [1:0]       elem_q, elem_d;
    logic [2:0]       unit_q, unit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic [2:0]       unit_len;

    // D = dash dot dot; every element of O and M is a dash
    function automatic logic elem_is_dash(input logic [1:0] ch, input logic [1:0] el);
        return (ch != 2'd0) || (el == 2'd0);
    endfunction

    // Index of the final element of each character (D:3, O:3, M:2 elements)
    function automatic logic [1:0] last_elem(input logic [1:0] ch);
        case (ch)
            2'd0:    return 2'd2;
            2'd1:    return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    // Number of Morse units spent in the current state
    function automatic logic [2:0] state_units(input logic [1:0] st, input logic dash);
        case (st)
            MARK:     return dash ? 3'd3 : 3'd1;
            ELEM_GAP: return 3'd1;
            CHAR_GAP: return 3'd3;
            default:  return 3'd7;
        endcase
    endfunction

    // Next-state logic: count cycles within a unit, units within a state,
    // then step to the next element, character, or back to D.
    // The LED register follows the current state, so it lights on the first
    // edge after reset while the machine sits at D dash, unit 0.
    always_comb begin
        state_d  = state_q;
        char_d   = char_q;
        elem_d   = elem_q;
        unit_d   = unit_q;
        cnt_d    = cnt_q;
        unit_len = state_units(state_q, elem_is_dash(char_q, elem_q));
        led_d    = (state_q == MARK);

        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            if (unit_q != unit_len - 3'd1) begin
                unit_d = unit_q + 3'd1;
            end else begin
                unit_d = '0;
                case (state_q)
                    MARK: begin
                        if (elem_q == last_elem(char_q)) begin
                            state_d = (char_q == 2'd2) ? WORD_GAP : CHAR_GAP;
                        end else begin
                            state_d = ELEM_GAP;
                        end
                    end
                    ELEM_GAP: begin
                        state_d = MARK;
                        elem_d  = elem_q + 2'd1;
                    end
                    CHAR_GAP: begin
                        state_d = MARK;
                        char_d  = char_q + 2'd1;
                        elem_d  = '0;
                    end
                    default: begin
                        state_d = MARK;
                        char_d  = '0;
                        elem_d  = '0;
                    end
                endcase
            end
        end
    end

    // State registers; reset parks the machine at D dash with the LED dark
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= MARK;
            char_q  <= '0;
            elem_q  <= '0;
            unit_q  <= '0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            elem_q  <= elem_d;
            unit_q  <= unit_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    assign oLED = led_q;

endmodule

// File: tb/tb_dom.sv
// tb_dom: directed checks of the DOM Morse blinker with UNIT_CYCLES = 4 and 1.
module tb_dom;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    logic led4;
    logic led1;

    always #10 iCLK = ~iCLK;

    dom #(.UNIT_CYCLES(4)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .oLED (led4)
    );

    dom #(.UNIT_CYCLES(1)) dut1 (
        .iCLK (iCLK),
        .iRST (iRST),
        .oLED (led1)
    );

    int errors = 0;
    int checks = 0;

    // Run lengths of one period at 4 cycles/unit, starting with a lit run
    int runs[16] = '{12, 4, 4, 4, 4, 12, 12, 4, 12, 4, 12, 12, 12, 4, 12, 28};

    logic s4[0:479];
    logic s1[0:79];
    logic pat1[0:37];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Measure nruns alternating runs in s4 from base (first run lit), bounded by lim
    task automatic runs_check(input string tag, input int base, input int nruns, input int lim);
        int idx;
        idx = base;
        for (int r = 0; r < nruns; r++) begin
            int   len;
            logic lvl;
            len = 0;
            lvl = (r % 2 == 0);
            while (idx < lim && s4[idx] === lvl && len < 64) begin
                len++;
                idx++;
            end
            check($sformatf("%s_run%0d", tag, r), len, runs[r]);
        end
    endtask

    initial begin
        int lit;
        int zeros;
        int bad;
        int pos;

        // Expected one-cycle-per-unit pattern derived from the run list
        pos = 0;
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < runs[r] / 4; j++) begin
                pat1[pos] = (r % 2 == 0);
                pos++;
            end
        end

        // Hold reset for 5 cycles
        iRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("rst_hold%0d", i), led4, 1'b0);
        end

        // Release and capture
        iRST = 1'b0;
        for (int k = 0; k < 460; k++) begin
            step();
            s4[k] = led4;
            if (k < 80) s1[k] = led1;
        end

        check("first_edge_lit", s4[0], 1'b1);
        for (int p = 0; p < 3; p++) begin
            runs_check($sformatf("period%0d", p), p * 152, 16, 460);
        end

        lit = 0;
        for (int i = 0; i < 152; i++) if (s4[i] === 1'b1) lit++;
        check("lit_count", lit, 80);
        zeros = 0;
        for (int i = 124; i < 152; i++) if (s4[i] === 1'b0) zeros++;
        check("word_gap_dark", zeros, 28);
        check("cycle153_lit", s4[152], 1'b1);

        for (int p = 0; p < 2; p++) begin
            bad = 0;
            for (int i = 0; i < 38; i++) if (s1[p * 38 + i] !== pat1[i]) bad++;
            check($sformatf("unit1_period%0d_mismatches", p), bad, 0);
        end

        // Advance into the O middle dash (cycle 60 of the period)
        for (int i = 0; i < 57; i++) step();
        check("o_mid_dash_lit", led4, 1'b1);

        iRST = 1'b1;
        step();
        check("mid_rst_dark", led4, 1'b0);
        iRST = 1'b0;
        for (int k = 0; k < 52; k++) begin
            step();
            s4[k] = led4;
        end
        runs_check("after_rst", 0, 7, 52);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
